spi_master_injector: RTL
========================

Name: spi_master_injector

Overview:
- SPI mode-0 initiator that lets the MITM logic originate its own transactions toward the real slave, instead of only forwarding the master's traffic.
- Serializes bytes from a valid/ready stream onto sclk_out/mosi_out/ss_out and deserializes miso_in into received bytes.
- Sits beside MitmControl on sys_clk (120 MHz). miso_in arrives already synchronized.

Parameters:
- DATA_SIZE, 8: bits per word.
- CLK_DIV, 6: sclk half-period in sys_clk cycles, minimum 1. The default gives 10 MHz sclk.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- tx_data  in  DATA_SIZE  word to transmit.
- tx_last  in  1  qualifies tx_data; 1 = final word of the frame.
- tx_valid  in  1  tx_data/tx_last valid.
- tx_ready  out  1  word accepted when tx_valid && tx_ready.
- rx_data  out  DATA_SIZE  word sampled from miso_in.
- rx_valid  out  1  one-cycle pulse, rx_data valid.
- busy  out  1  high whenever state != IDLE.
- miso_in  in  1  synchronized slave data.
- mosi_out  out  1  serial data to slave.
- sclk_out  out  1  serial clock, idle low.
- ss_out  out  1  slave select, active low.

Behaviour:
- All outputs are registered.
- Reset values: sclk_out 0, ss_out 1, mosi_out 0, rx_data 0, rx_valid 0, tx_ready 0, busy 0. The first cycle after release enters IDLE with tx_ready 1.
- State IDLE: tx_ready=1, ss_out=1.
  - On handshake at cycle T, the word is loaded into the shift register.
  - At T+1: ss_out=0, mosi_out=first bit (MSB), state LOW.
- State LOW: sclk_out=0 for CLK_DIV cycles.
  - Then sclk_out rises, and miso_in is sampled into the rx shift register in that same cycle.
  - State becomes HIGH.
- State HIGH: sclk_out=1 for CLK_DIV cycles, then sclk_out falls.
  - If bits remain: mosi_out=next bit in the falling-edge cycle, state LOW.
  - After bit DATA_SIZE: state WDONE.
- Word time: exactly 2*CLK_DIV*DATA_SIZE cycles from ss_out low to the last falling edge. The first rising edge is at T+1+CLK_DIV.
- WDONE:
  - On entry: rx_data updated and rx_valid=1 for exactly one cycle.
  - If the current word had tx_last=1: tx_ready=0, state HOLD.
  - Else tx_ready=1, sclk_out=0, ss_out stays 0; the block waits indefinitely for tx_valid.
  - Handshake in WDONE loads the next word and sets mosi_out=its first bit the next cycle, state LOW. This gives back-to-back words within one ss frame.
- HOLD: ss_out=0, sclk_out=0 for CLK_DIV cycles, then ss_out=1, state GAP.
- GAP: ss_out=1, tx_ready=0 for CLK_DIV cycles, then IDLE. This guarantees minimum deselect time between frames.
- tx_ready is 0 in LOW, HIGH, HOLD and GAP. A tx_valid asserted there is held off, not dropped.
- tx_data/tx_last are sampled only on handshake. Changes afterward have no effect on the word in flight.
- Counters:
  - bit counter width $clog2(DATA_SIZE+1), cleared on load.
  - divider counter width $clog2(CLK_DIV+1), reloaded at every phase change.
  - No wrap beyond DATA_SIZE.
- rx_valid and the WDONE tx_ready=1 may coincide. Both are valid in that same cycle.
- Asynchronous reset mid-word: immediately sclk_out=0, ss_out=1. The partial word is discarded and no rx_valid pulse is produced.
- CLK_DIV=1: each phase lasts one cycle. All transitions above still hold.

Optional Feature:
- Macro: SPI_LSB_FIRST_EN.
- Defined: words shift LSB first on mosi_out, and received bits fill rx_data LSB first.
- Undefined (default): MSB first in both directions.
- Timing is identical in both builds.

Test Plan:
- Single word, CLK_DIV=2: tx_data=0xA5, tx_last=1, slave model returns 0x3C. Required:
  - mosi bits 1,0,1,0,0,1,0,1.
  - 8 sclk pulses, each 2 high / 2 low cycles.
  - rx_data=0x3C with a single rx_valid pulse.
  - ss_out low for 32+2 cycles, then high for ≥2 cycles before tx_ready=1.
- Two-word frame: 0x12 (last=0) then 0x34 (last=1), offered immediately. Required:
  - ss_out stays low across both words.
  - 16 sclk pulses.
  - Two rx_valid pulses, 0x12 and 0x34 with loopback miso=mosi.
- Stall: 0x55 last=0, next word withheld for 20 cycles. Required:
  - sclk_out=0, ss_out=0, tx_ready=1 throughout the wait.
  - Frame resumes correctly when 0xAA is offered.
- Backpressure: tx_valid held high with 0xFF during HOLD/GAP. Required:
  - No handshake until IDLE.
  - Word sent exactly once, in a new ss frame.
- Reset mid-word: assert rst=0 after the 3rd rising edge. Required:
  - Same cycle: sclk_out=0, ss_out=1, rx_valid=0.
  - After release, 0x81 transfers cleanly.
- SPI_LSB_FIRST_EN defined: 0x01 sends mosi 1,0,0,0,0,0,0,0. Slave returning bits 1,1,0,0,0,0,0,0 gives rx_data=0x03.

Source files
------------

// File: rtl/spi_master_injector.sv
// SPI mode-0 initiator that originates transactions toward the slave from a valid/ready word stream.
// Build option SPI_LSB_FIRST_EN: shift LSB first in both directions (default is MSB first).
module spi_master_injector #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned CLK_DIV   = 6
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] tx_data,
  input  logic                 tx_last,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  input  logic                 miso_in,
  output logic                 mosi_out,
  output logic                 sclk_out,
  output logic                 ss_out
);

  localparam int unsigned CNT_W = $clog2(DATA_SIZE + 1);
  localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] WORD_BITS  = CNT_W'(DATA_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    WDONE,
    HOLD,
    GAP
  } state_e;

  state_e               state_q;
  logic [DATA_SIZE-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_SIZE-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_SIZE-1:0] rx_data_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [DIV_W-1:0]     div_q;
  logic                 last_q, sclk_q, ss_q, rx_valid_q, tx_ready_q, busy_q;
  logic                 div_done, handshake;

  assign div_done  = (div_q == '0);
  assign handshake = tx_valid && tx_ready_q;

  // mosi is the outgoing end of the tx shift register, so it is a flop output too.
`ifdef SPI_LSB_FIRST_EN
  assign tx_shift_d = {1'b0, tx_shift_q[DATA_SIZE-1:1]};
  assign rx_shift_d = {miso_in, rx_shift_q[DATA_SIZE-1:1]};
  assign mosi_out   = tx_shift_q[0];
`else
  assign tx_shift_d = {tx_shift_q[DATA_SIZE-2:0], 1'b0};
  assign rx_shift_d = {rx_shift_q[DATA_SIZE-2:0], miso_in};
  assign mosi_out   = tx_shift_q[DATA_SIZE-1];
`endif

  always_ff @(posedge sys_clk or negedge rst) begin
    // NOTE: data registers are reset as well, so rx_data and mosi have defined values before the first word.
    if (!rst) begin
      state_q    <= IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      div_q      <= '0;
      last_q     <= 1'b0;
      sclk_q     <= 1'b0;
      ss_q       <= 1'b1;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every branch below see pre-edge values;
      // the default here turns rx_valid into a single-cycle pulse.
      rx_valid_q <= 1'b0;
      unique case (state_q)
        IDLE, WDONE: begin
          if (handshake) begin
            tx_shift_q <= tx_data;
            last_q     <= tx_last;
            bit_cnt_q  <= '0;
            div_q      <= DIV_RELOAD;
            ss_q       <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= LOW;
          end else begin
            tx_ready_q <= 1'b1;
          end
        end
        LOW: begin
          if (div_done) begin
            sclk_q     <= 1'b1;
            rx_shift_q <= rx_shift_d;
            bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
            div_q      <= DIV_RELOAD;
            state_q    <= HIGH;
          end else begin
            div_q <= div_q - DIV_W'(1);
          end
        end
        HIGH: begin
          if (div_done) begin
            sclk_q <= 1'b0;
            div_q  <= DIV_RELOAD;
            if (bit_cnt_q == WORD_BITS) begin
              rx_data_q  <= rx_shift_q;
              rx_valid_q <= 1'b1;
              // A final word heads straight for deselect; otherwise park with ss held low.
              if (last_q) begin
                state_q <= HOLD;
              end else begin
                tx_ready_q <= 1'b1;
                state_q    <= WDONE;
              end
            end else begin
              tx_shift_q <= tx_shift_d;
              state_q    <= LOW;
            end
          end else begin
            div_q <= div_q - DIV_W'(1);
          end
        end
        HOLD: begin
          if (div_done) begin
            ss_q    <= 1'b1;
            div_q   <= DIV_RELOAD;
            state_q <= GAP;
          end else begin
            div_q <= div_q - DIV_W'(1);
          end
        end
        GAP: begin
          if (div_done) begin
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            div_q <= div_q - DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign sclk_out = sclk_q;
  assign ss_out   = ss_q;

endmodule
